// File: rtl/dvb_s2_ts_gen.sv
`default_nettype none
// dvb_s2_ts_gen: 188-byte MPEG-TS packet source for the DVB-S2 modulator TS input.
// Rev 1.0 - initial release
module dvb_s2_ts_gen #(
  parameter logic [14:0] PRBS_SEED = 15'h4A80,
  parameter int          PKT_LEN   = 188
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [12:0] pid,
  input  logic [15:0] gap_len,
  input  logic [1:0]  payload_mode,
  input  logic        ts_ready,
  output logic [7:0]  ts_data,
  output logic        ts_syn,
  output logic        ts_valid,
  output logic        busy,
  output logic [31:0] pkt_cnt,
  output logic [3:0]  cc_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  idx;
  logic [15:0] gap_cnt;
  logic [12:0] pid_q;
  logic [15:0] gap_q;
  logic [1:0]  mode_q;
  logic [3:0]  cc;
  logic [31:0] pkt_cnt_q;
  logic [14:0] lfsr, lfsr_nx;
  logic [7:0]  prbs_byte;
  logic        start, load_seed, xfer, last_byte, gap_done;

  assign ts_valid  = (state == HDR) || (state == PAY);
  assign ts_syn    = (state == HDR) && (idx == 8'd0);
  assign busy      = (state != IDLE);
  assign pkt_cnt   = pkt_cnt_q;
  assign cc_out    = cc;
  assign xfer      = ts_valid && ts_ready;
  assign last_byte = (state == PAY) && (idx == 8'(PKT_LEN - 1));
  assign gap_done  = (state == GAP) && (gap_cnt == gap_q - 16'd1);

  // Next PRBS byte, MSB generated first; only committed when the byte is accepted.
  always_comb begin : prbs
    logic [14:0] r;
    logic        b;
    r         = lfsr;
    b         = 1'b0;
    prbs_byte = 8'h00;
    for (int k = 0; k < 8; k++) begin
      b         = r[14] ^ r[13];
      prbs_byte = {prbs_byte[6:0], b};
      r         = {r[13:0], b};
    end
    lfsr_nx = r;
  end

  always_comb begin
    ts_data = 8'h00;
    if (state == HDR) begin
      case (idx[1:0])
        2'd0:    ts_data = 8'h47;
        2'd1:    ts_data = {3'b000, pid_q[12:8]};
        2'd2:    ts_data = pid_q[7:0];
        default: ts_data = {4'b0001, cc};
      endcase
    end else if (state == PAY) begin
      case (mode_q)
        2'd1:    ts_data = 8'hFF;
        2'd2:    ts_data = prbs_byte;
        default: ts_data = idx - 8'd4;
      endcase
    end
  end

  always_comb begin
    state_nx  = state;
    start     = 1'b0;
    load_seed = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_nx  = HDR;
          start     = 1'b1;
          load_seed = 1'b1;
        end
      end
      HDR: begin
        if (xfer && idx == 8'd3) state_nx = PAY;
      end
      PAY: begin
        if (xfer && last_byte) begin
          if (gap_q != 16'd0) begin
            state_nx = GAP;
          end else if (enable) begin
            state_nx = HDR;
            start    = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_done) begin
          if (enable) begin
            state_nx = HDR;
            start    = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= 8'd0;
      gap_cnt   <= 16'd0;
      pid_q     <= 13'd0;
      gap_q     <= 16'd0;
      mode_q    <= 2'd0;
      cc        <= 4'd0;
      pkt_cnt_q <= 32'd0;
      lfsr      <= PRBS_SEED;
    end else begin
      state <= state_nx;
      // Configuration is frozen per packet at the moment byte 0 is first presented.
      if (start) begin
        idx    <= 8'd0;
        pid_q  <= pid;
        gap_q  <= gap_len;
        mode_q <= payload_mode;
      end else if (xfer) begin
        idx <= idx + 8'd1;
      end
      gap_cnt <= (state == GAP) ? gap_cnt + 16'd1 : 16'd0;
      if (load_seed)
        lfsr <= PRBS_SEED;
      else if (xfer && state == PAY && mode_q == 2'd2)
        lfsr <= lfsr_nx;
      if (xfer && last_byte) begin
        pkt_cnt_q <= pkt_cnt_q + 32'd1;
        cc        <= cc + 4'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dvb_s2_ts_gen.sv
`default_nettype none
// tb_dvb_s2_ts_gen: scoreboard bench for the TS packet generator.
module tb_dvb_s2_ts_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [12:0] pid = 13'h0100;
  logic [15:0] gap_len = 16'd0;
  logic [1:0]  payload_mode = 2'd0;
  logic        ts_ready = 1'b1;
  logic [7:0]  ts_data;
  logic        ts_syn;
  logic        ts_valid;
  logic        busy;
  logic [31:0] pkt_cnt;
  logic [3:0]  cc_out;

  dvb_s2_ts_gen dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pid(pid), .gap_len(gap_len),
    .payload_mode(payload_mode), .ts_ready(ts_ready), .ts_data(ts_data),
    .ts_syn(ts_syn), .ts_valid(ts_valid), .busy(busy), .pkt_cnt(pkt_cnt),
    .cc_out(cc_out)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [8:0]  q[$];
  logic [14:0] m_lfsr;
  int          done_pkts = 0;
  int          cur = 0;
  int          gap_run = 0;
  int          exp_gap = 0;
  bit          gap_armed = 0;
  bit          rnd_ready = 0;
  int          base;

  function automatic void check(bit ok, string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Expected stream for one packet, built from the packet format rules.
  task automatic push_pkt(input logic [12:0] p, input logic [3:0] c, input logic [1:0] m);
    logic [7:0] d;
    logic       b;
    for (int i = 0; i < 188; i++) begin
      case (i)
        0: d = 8'h47;
        1: d = {3'b000, p[12:8]};
        2: d = p[7:0];
        3: d = {4'h1, c};
        default: begin
          if (m == 2'd1) d = 8'hFF;
          else if (m == 2'd2) begin
            d = 8'h00;
            for (int k = 0; k < 8; k++) begin
              b      = m_lfsr[14] ^ m_lfsr[13];
              d      = {d[6:0], b};
              m_lfsr = {m_lfsr[13:0], b};
            end
          end else d = 8'(i - 4);
        end
      endcase
      q.push_back({(i == 0), d});
    end
  endtask

  initial begin : ready_drv
    forever begin
      @(posedge clk); #1;
      ts_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops and compares on every transfer, checks stall stability and gaps.
  initial begin : monitor
    bit         stalled;
    logic [8:0] st, got, e;
    stalled = 0;
    st = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cur = 0; gap_run = 0; gap_armed = 0; stalled = 0;
      end else begin
        got = {ts_syn, ts_data};
        if (stalled)
          check(ts_valid && got == st, "stall_hold", {ts_valid, got}, {1'b1, st});
        if (cur != 0)
          check(ts_valid, "valid_cont", ts_valid, 1);
        if (!ts_valid) gap_run++;
        else begin
          if (cur == 0 && gap_armed) begin
            check(gap_run == exp_gap, "gap_len", gap_run, exp_gap);
            gap_armed = 0;
          end
          gap_run = 0;
        end
        if (ts_valid && ts_ready) begin
          if (q.size() == 0) check(0, "unexpected_byte", got, 0);
          else begin
            e = q.pop_front();
            check(got == e, $sformatf("byte p%0d b%0d", done_pkts, cur), got, e);
          end
          cur++;
          if (cur == 188) begin
            cur = 0; done_pkts++; gap_armed = 1; gap_run = 0;
          end
        end
        stalled = ts_valid && !ts_ready;
        st = got;
      end
    end
  end

  task automatic wait_pos(input int pk, input int by);
    int t = 0;
    while (!(done_pkts > pk || (done_pkts == pk && cur >= by))) begin
      @(posedge clk); #1;
      t++;
      if (t > 10000) begin
        check(0, "timeout_pos", done_pkts, pk);
        return;
      end
    end
  endtask

  task automatic stop_and_idle();
    int t = 0;
    enable = 1'b0;
    while (busy) begin
      @(posedge clk); #1;
      t++;
      if (t > 10000) begin
        check(0, "timeout_idle", busy, 0);
        break;
      end
    end
    gap_armed = 0;
    check(busy == 1'b0, "busy_idle", busy, 0);
    check(q.size() == 0, "queue_drained", q.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    q.delete();
    rst_n = 1'b1;
  endtask

  task automatic run(input int n, input logic [12:0] p, input logic [3:0] c0,
                     input logic [1:0] m, input logic [15:0] g);
    pid = p; gap_len = g; payload_mode = m; exp_gap = int'(g);
    m_lfsr = 15'h4A80;
    for (int i = 0; i < n; i++) push_pkt(p, c0 + 4'(i), m);
    base = done_pkts;
    enable = 1'b1;
    wait_pos(base + n - 1, 1);
    stop_and_idle();
  endtask

  initial begin
    // Reset values
    @(posedge clk); @(posedge clk); #1;
    check(ts_valid == 0, "rst_valid", ts_valid, 0);
    check(ts_syn == 0, "rst_syn", ts_syn, 0);
    check(ts_data == 0, "rst_data", ts_data, 0);
    check(busy == 0, "rst_busy", busy, 0);
    check(pkt_cnt == 0, "rst_pkt_cnt", pkt_cnt, 0);
    check(cc_out == 0, "rst_cc", cc_out, 0);
    rst_n = 1'b1;

    // Default flow, back-to-back
    run(2, 13'h0100, 4'd0, 2'd0, 16'd0);
    check(pkt_cnt == 2, "flow_pkt_cnt", pkt_cnt, 2);
    check(cc_out == 2, "flow_cc", cc_out, 2);

    // Inter-packet gap
    run(2, 13'h0100, 4'd2, 2'd0, 16'd5);
    check(pkt_cnt == 4, "gap_pkt_cnt", pkt_cnt, 4);

    // Backpressure, constant-FF payload
    rnd_ready = 1;
    run(2, 13'h0100, 4'd4, 2'd1, 16'd0);
    rnd_ready = 0;
    check(pkt_cnt == 6, "bp_pkt_cnt", pkt_cnt, 6);

    // Enable dropped while byte 50 presented
    do_reset();
    pid = 13'h0100; gap_len = 16'd0; payload_mode = 2'd0; exp_gap = 0;
    push_pkt(13'h0100, 4'd0, 2'd0);
    base = done_pkts;
    enable = 1'b1;
    wait_pos(base, 50);
    stop_and_idle();
    check(pkt_cnt == 1, "drop_pkt_cnt", pkt_cnt, 1);
    run(1, 13'h0100, 4'd1, 2'd0, 16'd0);
    check(pkt_cnt == 2, "reen_pkt_cnt", pkt_cnt, 2);

    // CC wrap over 17 packets with a mid-packet PID change
    do_reset();
    pid = 13'h0100; gap_len = 16'd0; payload_mode = 2'd0;
    for (int i = 0; i < 16; i++) push_pkt(13'h0100, 4'(i), 2'd0);
    push_pkt(13'h1FFF, 4'd0, 2'd0);
    base = done_pkts;
    enable = 1'b1;
    wait_pos(base + 15, 100);
    pid = 13'h1FFF;
    wait_pos(base + 16, 1);
    stop_and_idle();
    check(pkt_cnt == 17, "wrap_pkt_cnt", pkt_cnt, 17);
    check(cc_out == 1, "wrap_cc", cc_out, 1);

    // PRBS payload across 3 packets with random backpressure
    do_reset();
    rnd_ready = 1;
    run(3, 13'h0100, 4'd0, 2'd2, 16'd0);
    rnd_ready = 0;
    check(pkt_cnt == 3, "prbs_pkt_cnt", pkt_cnt, 3);

    // Reset pulsed mid-payload
    pid = 13'h0100; payload_mode = 2'd0; gap_len = 16'd0;
    push_pkt(13'h0100, 4'd3, 2'd0);
    base = done_pkts;
    enable = 1'b1;
    wait_pos(base, 100);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check(ts_valid == 0, "midrst_valid", ts_valid, 0);
    check(pkt_cnt == 0, "midrst_pkt_cnt", pkt_cnt, 0);
    check(cc_out == 0, "midrst_cc", cc_out, 0);
    q.delete();
    push_pkt(13'h0100, 4'd0, 2'd0);
    base = done_pkts;
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_pos(base, 1);
    stop_and_idle();
    check(pkt_cnt == 1, "restart_pkt_cnt", pkt_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
